// File: rtl/axil_cmd_master.sv
// axil_cmd_master: turns single-beat register commands into AXI-Lite write
// or read transactions on the cbus, one transaction at a time, and returns
// the slave's response on a valid/ready response port.
module axil_cmd_master #(
  parameter int         ADDR_WIDTH = 32,
  parameter int         DATA_WIDTH = 32,
  parameter logic [2:0] PROT       = 3'b000
) (
  input  logic                    clk,
  input  logic                    rstn,
  // command port
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,
  // response port
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic                    rsp_write,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]              rsp_resp,
  output logic                    busy,
  // AW channel
  output logic [ADDR_WIDTH-1:0]   cbus_awaddr,
  output logic [2:0]              cbus_awprot,
  output logic                    cbus_awvalid,
  input  logic                    cbus_awready,
  // W channel
  output logic [DATA_WIDTH-1:0]   cbus_wdata,
  output logic [DATA_WIDTH/8-1:0] cbus_wstrb,
  output logic                    cbus_wvalid,
  input  logic                    cbus_wready,
  // B channel
  input  logic [1:0]              cbus_bresp,
  input  logic                    cbus_bvalid,
  output logic                    cbus_bready,
  // AR channel
  output logic [ADDR_WIDTH-1:0]   cbus_araddr,
  output logic [2:0]              cbus_arprot,
  output logic                    cbus_arvalid,
  input  logic                    cbus_arready,
  // R channel
  input  logic [DATA_WIDTH-1:0]   cbus_rdata,
  input  logic [1:0]              cbus_rresp,
  input  logic                    cbus_rvalid,
  output logic                    cbus_rready
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WADDR = 3'd1,
    WRESP = 3'd2,
    RADDR = 3'd3,
    RDATA = 3'd4,
    RESP  = 3'd5
  } state_t;

  state_t                  state_reg,     state_next;
  logic [ADDR_WIDTH-1:0]   addr_reg,      addr_next;
  logic [DATA_WIDTH-1:0]   wdata_reg,     wdata_next;
  logic [STRB_WIDTH-1:0]   wstrb_reg,     wstrb_next;
  logic                    aw_done_reg,   aw_done_next;
  logic                    w_done_reg,    w_done_next;
  logic                    rsp_write_reg, rsp_write_next;
  logic [DATA_WIDTH-1:0]   rsp_rdata_reg, rsp_rdata_next;
  logic [1:0]              rsp_resp_reg,  rsp_resp_next;

  // Channel handshakes and port controls are pure decodes of the state and
  // done flags, so an asynchronous reset drops every valid/ready at once.
  // cmd_ready is additionally held low while reset is asserted.
  assign cmd_ready    = (state_reg == IDLE) && rstn;
  assign busy         = (state_reg != IDLE);
  assign rsp_valid    = (state_reg == RESP);
  assign rsp_write    = rsp_write_reg;
  assign rsp_rdata    = rsp_rdata_reg;
  assign rsp_resp     = rsp_resp_reg;

  assign cbus_awaddr  = addr_reg;
  assign cbus_awprot  = PROT;
  assign cbus_awvalid = (state_reg == WADDR) && !aw_done_reg;
  assign cbus_wdata   = wdata_reg;
  assign cbus_wstrb   = wstrb_reg;
  assign cbus_wvalid  = (state_reg == WADDR) && !w_done_reg;
  assign cbus_bready  = (state_reg == WRESP);
  assign cbus_araddr  = addr_reg;
  assign cbus_arprot  = PROT;
  assign cbus_arvalid = (state_reg == RADDR);
  assign cbus_rready  = (state_reg == RDATA);

  // State, command and response registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg     <= IDLE;
      addr_reg      <= '0;
      wdata_reg     <= '0;
      wstrb_reg     <= '0;
      aw_done_reg   <= 1'b0;
      w_done_reg    <= 1'b0;
      rsp_write_reg <= 1'b0;
      rsp_rdata_reg <= '0;
      rsp_resp_reg  <= 2'b00;
    end else begin
      state_reg     <= state_next;
      addr_reg      <= addr_next;
      wdata_reg     <= wdata_next;
      wstrb_reg     <= wstrb_next;
      aw_done_reg   <= aw_done_next;
      w_done_reg    <= w_done_next;
      rsp_write_reg <= rsp_write_next;
      rsp_rdata_reg <= rsp_rdata_next;
      rsp_resp_reg  <= rsp_resp_next;
    end
  end

  // Next-state logic: accept a command, run its AXI channels, hold the response.
  always_comb begin
    state_next     = state_reg;
    addr_next      = addr_reg;
    wdata_next     = wdata_reg;
    wstrb_next     = wstrb_reg;
    aw_done_next   = aw_done_reg;
    w_done_next    = w_done_reg;
    rsp_write_next = rsp_write_reg;
    rsp_rdata_next = rsp_rdata_reg;
    rsp_resp_next  = rsp_resp_reg;

    case (state_reg)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          addr_next      = cmd_addr;
          wdata_next     = cmd_wdata;
          wstrb_next     = cmd_wstrb;
          rsp_write_next = cmd_write;
          aw_done_next   = 1'b0;
          w_done_next    = 1'b0;
          state_next     = cmd_write ? WADDR : RADDR;
        end
      end

      WADDR: begin
        // AW and W complete independently; each valid falls the cycle after
        // its own handshake, and we move on once both have completed.
        if (cbus_awvalid && cbus_awready) begin
          aw_done_next = 1'b1;
        end
        if (cbus_wvalid && cbus_wready) begin
          w_done_next = 1'b1;
        end
        if (aw_done_next && w_done_next) begin
          state_next = WRESP;
        end
      end

      WRESP: begin
        if (cbus_bvalid) begin
          rsp_resp_next  = cbus_bresp;
          rsp_write_next = 1'b1;
          rsp_rdata_next = '0;
          state_next     = RESP;
        end
      end

      RADDR: begin
        if (cbus_arready) begin
          state_next = RDATA;
        end
      end

      RDATA: begin
        if (cbus_rvalid) begin
          rsp_resp_next  = cbus_rresp;
          rsp_rdata_next = cbus_rdata;
          rsp_write_next = 1'b0;
          state_next     = RESP;
        end
      end

      RESP: begin
        if (rsp_ready) begin
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule
